// File: rtl/pe_pkg.sv
// Shared types and helpers for the double-buffered weight-stationary PE row.
// sat_add clamps a signed sum formed one bit wider back into the default accumulator width.
package pe_pkg;

    localparam int DATA_W_DEF = 19;
    localparam int ACC_W_DEF  = 2 * DATA_W_DEF;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } swap_state_e;

    function automatic logic signed [ACC_W_DEF-1:0] sat_add(
        input logic signed [ACC_W_DEF-1:0] a,
        input logic signed [ACC_W_DEF-1:0] b
    );
        logic signed [ACC_W_DEF:0] s;
        s = {a[ACC_W_DEF-1], a} + {b[ACC_W_DEF-1], b};
        if (s[ACC_W_DEF] != s[ACC_W_DEF-1]) begin
            sat_add = s[ACC_W_DEF] ? {1'b1, {(ACC_W_DEF-1){1'b0}}}
                                   : {1'b0, {(ACC_W_DEF-1){1'b1}}};
        end else begin
            sat_add = s[ACC_W_DEF-1:0];
        end
    endfunction

endpackage

// File: rtl/pe_row_db_cell.sv
// One PE cell: shadow/active weight pair, activation pipeline stage and partial-sum register.
// The sum register only updates on a valid activation, otherwise it holds.
module pe_cell_db
    import pe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = 2 * DATA_W,
    parameter bit SAT_EN = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [DATA_W-1:0] a_in,
    input  logic                     a_valid_in,
    input  logic                     shift,
    input  logic                     swap_exec,
    input  logic signed [DATA_W-1:0] w_in,
    input  logic signed [ACC_W-1:0]  sum_in,
    input  logic                     sum_valid_in,
    output logic signed [DATA_W-1:0] a_out,
    output logic                     a_valid_out,
    output logic signed [DATA_W-1:0] w_out,
    output logic signed [ACC_W-1:0]  sum_out,
    output logic                     sum_valid_out,
    output logic                     align_err
);

    localparam int PW = 2 * DATA_W;

    logic signed [DATA_W-1:0] w_shadow;
    logic signed [DATA_W-1:0] w_active;
    logic signed [PW-1:0]     prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  sum_next;

    assign prod     = PW'(a_in) * PW'(w_active);
    assign prod_ext = ACC_W'(prod);

    generate
        if (!SAT_EN) begin : g_wrap
            assign sum_next = sum_in + prod_ext;
        end else if (ACC_W == ACC_W_DEF) begin : g_sat_pkg
            assign sum_next = sat_add(sum_in, prod_ext);
        end else begin : g_sat
            logic signed [ACC_W:0] sum_wide;
            assign sum_wide = (ACC_W+1)'(sum_in) + (ACC_W+1)'(prod_ext);
            assign sum_next = (sum_wide[ACC_W] != sum_wide[ACC_W-1])
                            ? (sum_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                               : {1'b0, {(ACC_W-1){1'b1}}})
                            : sum_wide[ACC_W-1:0];
        end
    endgenerate

    assign w_out     = w_shadow;
    assign align_err = (sum_valid_in != a_valid_in);

    // Nonblocking copy means a same-cycle shift and swap gives active the pre-shift shadow.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_shadow      <= '0;
            w_active      <= '0;
            a_out         <= '0;
            a_valid_out   <= 1'b0;
            sum_out       <= '0;
            sum_valid_out <= 1'b0;
        end else begin
            if (shift) begin
                w_shadow <= w_in;
            end
            if (swap_exec) begin
                w_active <= w_shadow;
            end
            a_out         <= a_in;
            a_valid_out   <= a_valid_in;
            sum_valid_out <= a_valid_in;
            if (a_valid_in) begin
                sum_out <= sum_next;
            end
        end
    end

endmodule

// File: rtl/pe_row_db.sv
// One systolic GEMM row with double-buffered weights and a drain-safe weight swap.
// The swap waits until no cell holds a valid activation, so in-flight data always sees the old weights.
module pe_row_db
    import pe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int COLS   = 4,
    parameter int ACC_W  = 2 * DATA_W,
    parameter bit SAT_EN = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_W-1:0]        act_in,
    input  logic                     act_in_valid,
    output logic                     act_in_ready,
    output logic [DATA_W-1:0]        act_out,
    output logic                     act_out_valid,
    input  logic                     w_shift,
    input  logic [DATA_W*COLS-1:0]   in_weight_above,
    output logic [DATA_W*COLS-1:0]   out_weight_below,
    input  logic                     w_swap,
    output logic                     swap_done,
    input  logic [ACC_W*COLS-1:0]    in_sum,
    input  logic [COLS-1:0]          in_sum_valid,
    output logic [ACC_W*COLS-1:0]    out_sum,
    output logic [COLS-1:0]          out_sum_valid,
    output logic                     err_align
);

    swap_state_e state, state_next;

    logic              swap_exec;
    logic              busy;
    logic [DATA_W-1:0] a_chain [COLS+1];
    logic [COLS:0]     v_chain;
    logic [COLS-1:0]   align_err;

    assign act_in_ready = (state == IDLE);
    assign a_chain[0]   = act_in;
    assign v_chain[0]   = act_in_valid && act_in_ready;

    genvar c;
    generate
        for (c = 0; c < COLS; c++) begin : g_cell
            pe_cell_db #(
                .DATA_W (DATA_W),
                .ACC_W  (ACC_W),
                .SAT_EN (SAT_EN)
            ) u_cell (
                .clk           (clk),
                .rst           (rst),
                .a_in          (a_chain[c]),
                .a_valid_in    (v_chain[c]),
                .shift         (w_shift),
                .swap_exec     (swap_exec),
                .w_in          (in_weight_above[c*DATA_W +: DATA_W]),
                .sum_in        (in_sum[c*ACC_W +: ACC_W]),
                .sum_valid_in  (in_sum_valid[c]),
                .a_out         (a_chain[c+1]),
                .a_valid_out   (v_chain[c+1]),
                .w_out         (out_weight_below[c*DATA_W +: DATA_W]),
                .sum_out       (out_sum[c*ACC_W +: ACC_W]),
                .sum_valid_out (out_sum_valid[c]),
                .align_err     (align_err[c])
            );
        end
    endgenerate

    assign act_out       = a_chain[COLS];
    assign act_out_valid = v_chain[COLS];

    // Busy covers every cell register plus a beat being accepted this cycle.
    assign busy      = |v_chain;
    assign swap_done = swap_exec;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        swap_exec  = 1'b0;
        unique case (state)
            IDLE: begin
                if (w_swap) begin
                    state_next = PENDING;
                end
            end
            PENDING: begin
                if (!busy) begin
                    swap_exec  = 1'b1;
                    state_next = IDLE;
                end
            end
        endcase
        if (rst) begin
            swap_exec = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_align <= 1'b0;
        end else if (|align_err) begin
            err_align <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pe_row_db.sv
// Directed bench for pe_row_db: one saturating and one wrapping instance share the same stimulus.
module tb_pe_row_db;

    localparam int DW = 19;
    localparam int C  = 4;
    localparam int AW = 38;

    logic            clk = 1'b0;
    logic            rst;
    logic [DW-1:0]   act_in;
    logic            act_in_valid;
    logic            act_in_ready, act_in_ready_w;
    logic [DW-1:0]   act_out, act_out_w;
    logic            act_out_valid, act_out_valid_w;
    logic            w_shift;
    logic [DW*C-1:0] in_weight_above;
    logic [DW*C-1:0] out_weight_below, out_weight_below_w;
    logic            w_swap;
    logic            swap_done, swap_done_w;
    logic [AW*C-1:0] in_sum;
    logic [C-1:0]    in_sum_valid;
    logic [AW*C-1:0] out_sum, out_sum_w;
    logic [C-1:0]    out_sum_valid, out_sum_valid_w;
    logic            err_align, err_align_w;

    logic            align_on;
    logic [C-1:0]    man_sv;
    logic [C-1:0]    vpipe;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pe_row_db #(.DATA_W(DW), .COLS(C), .ACC_W(AW), .SAT_EN(1'b1)) dut (
        .clk (clk), .rst (rst),
        .act_in (act_in), .act_in_valid (act_in_valid), .act_in_ready (act_in_ready),
        .act_out (act_out), .act_out_valid (act_out_valid),
        .w_shift (w_shift), .in_weight_above (in_weight_above), .out_weight_below (out_weight_below),
        .w_swap (w_swap), .swap_done (swap_done),
        .in_sum (in_sum), .in_sum_valid (in_sum_valid),
        .out_sum (out_sum), .out_sum_valid (out_sum_valid), .err_align (err_align)
    );

    pe_row_db #(.DATA_W(DW), .COLS(C), .ACC_W(AW), .SAT_EN(1'b0)) dut_wrap (
        .clk (clk), .rst (rst),
        .act_in (act_in), .act_in_valid (act_in_valid), .act_in_ready (act_in_ready_w),
        .act_out (act_out_w), .act_out_valid (act_out_valid_w),
        .w_shift (w_shift), .in_weight_above (in_weight_above), .out_weight_below (out_weight_below_w),
        .w_swap (w_swap), .swap_done (swap_done_w),
        .in_sum (in_sum), .in_sum_valid (in_sum_valid),
        .out_sum (out_sum_w), .out_sum_valid (out_sum_valid_w), .err_align (err_align_w)
    );

    // Sum valids follow the accepted activation down the row so columns stay aligned.
    always @(posedge clk) begin
        if (rst) vpipe <= '0;
        else     vpipe <= {vpipe[C-2:0], act_in_valid && act_in_ready};
    end

    always_comb begin
        in_sum_valid = man_sv;
        if (align_on) in_sum_valid = {vpipe[C-2:0], act_in_valid && act_in_ready};
    end

    initial begin
        #300000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] osum(input int c);
        return out_sum[c*AW +: AW];
    endfunction

    function automatic logic [AW-1:0] osum_w(input int c);
        return out_sum_w[c*AW +: AW];
    endfunction

    task automatic load_w(input logic [DW*C-1:0] w);
        int n;
        w_shift = 1'b1; in_weight_above = w;
        tick();
        w_shift = 1'b0; w_swap = 1'b1;
        tick();
        w_swap = 1'b0;
        n = 0;
        while (!swap_done && n < 10) begin
            tick();
            n++;
        end
        chk("load_swap_done", swap_done, 1);
        tick();
    endtask

    task automatic drain();
        for (int i = 0; i < C + 1; i++) tick();
    endtask

    int beat, nexp, cyc, last_acc, lat, done_cyc;
    logic acc, swap_sent, seen;

    initial begin
        // Reset with random inputs
        rst = 1'b1;
        align_on = 1'b0;
        act_in = DW'($urandom); act_in_valid = 1'b1;
        w_shift = 1'b1; w_swap = 1'b1;
        in_weight_above = (DW*C)'({$urandom, $urandom, $urandom});
        in_sum = (AW*C)'({$urandom, $urandom, $urandom, $urandom, $urandom});
        man_sv = C'($urandom);
        tick();
        tick();
        chk("rst_out_sum", out_sum[63:0], 0);
        chk("rst_out_sum_hi", 64'(out_sum[AW*C-1:64]), 0);
        chk("rst_out_sum_valid", out_sum_valid, 0);
        chk("rst_act_out", act_out, 0);
        chk("rst_act_out_valid", act_out_valid, 0);
        chk("rst_weight_below", out_weight_below, 0);
        chk("rst_ready", act_in_ready, 1);
        chk("rst_swap_done", swap_done, 0);
        chk("rst_err_align", err_align, 0);
        act_in = '0; act_in_valid = 1'b0; w_shift = 1'b0; w_swap = 1'b0;
        in_weight_above = '0; in_sum = '0; man_sv = '0;
        align_on = 1'b1;
        rst = 1'b0;
        tick();

        // Load {4,3,2,1} and swap
        w_shift = 1'b1; in_weight_above = {19'd4, 19'd3, 19'd2, 19'd1};
        tick();
        w_shift = 1'b0;
        chk("t2_weight_below", out_weight_below, {19'd4, 19'd3, 19'd2, 19'd1});
        w_swap = 1'b1;
        tick();
        w_swap = 1'b0;
        chk("t2_swap_done", swap_done, 1);
        chk("t2_ready_pending", act_in_ready, 0);
        tick();
        chk("t2_swap_done_clr", swap_done, 0);
        chk("t2_ready_back", act_in_ready, 1);

        act_in = 19'd5; act_in_valid = 1'b1;
        tick();
        act_in_valid = 1'b0; act_in = '0;
        for (int c = 0; c < C; c++) begin
            chk($sformatf("t2_sum%0d", c), osum(c), 64'(5 * (c + 1)));
            chk($sformatf("t2_sumv%0d", c), out_sum_valid, 64'(4'b0001 << c));
            if (c < C - 1) tick();
        end
        chk("t2_act_out", act_out, 5);
        chk("t2_act_out_valid", act_out_valid, 1);
        tick();
        chk("t2_act_out_valid_clr", act_out_valid, 0);
        chk("t2_sum0_hold", osum(0), 5);
        drain();

        // Overlap: compute with 1s while shadow takes 7s; swap requested at beat 3
        load_w({4{19'd1}});
        beat = 0; nexp = 0; cyc = 0; last_acc = -100; lat = -1; done_cyc = -1; swap_sent = 1'b0;
        in_weight_above = {4{19'd7}};
        while (nexp < 8 && cyc < 60) begin
            act_in       = DW'(beat + 1);
            act_in_valid = (beat < 8);
            w_shift      = (cyc == 0);
            w_swap       = (beat == 3) && !swap_sent;
            if (w_swap) swap_sent = 1'b1;
            acc = act_in_valid && act_in_ready;
            tick();
            cyc++;
            if (acc) begin
                last_acc = cyc;
                beat++;
            end
            if (w_swap) chk("t3_ready_low", act_in_ready, 0);
            if (swap_done && done_cyc < 0) begin
                done_cyc = cyc;
                lat = cyc - last_acc;
            end
            if (out_sum_valid[3]) begin
                chk($sformatf("t3_col3_beat%0d", nexp), osum(3), 64'((nexp + 1) * ((nexp < 4) ? 1 : 7)));
                nexp++;
            end
        end
        act_in_valid = 1'b0; w_shift = 1'b0; w_swap = 1'b0; act_in = '0;
        chk("t3_all_beats", 64'(nexp), 8);
        chk("t3_swap_latency", 64'(lat), 4);
        drain();

        // Saturation, both polarities
        load_w({4{19'h3FFFF}});
        act_in = 19'h3FFFF; act_in_valid = 1'b1;
        in_sum = '0; in_sum[AW-1:0] = 38'h1F_FFFF_FFFF;
        tick();
        act_in_valid = 1'b0; in_sum = '0;
        chk("t4_sat_pos", osum(0), 38'h1F_FFFF_FFFF);
        chk("t4_wrap_pos", osum_w(0), 38'h2F_FFF8_0000);
        drain();
        act_in = 19'h40000; act_in_valid = 1'b1;
        in_sum[AW-1:0] = 38'h20_0000_0000;
        tick();
        act_in_valid = 1'b0; in_sum = '0; act_in = '0;
        chk("t4_sat_neg", osum(0), 38'h20_0000_0000);
        chk("t4_wrap_neg", osum_w(0), 38'h10_0004_0000);
        drain();

        // Misalignment on column 2
        chk("t5_err_before", err_align, 0);
        align_on = 1'b0; man_sv = 4'b0100;
        tick();
        man_sv = '0;
        chk("t5_err_set", err_align, 1);
        tick(); tick(); tick();
        chk("t5_err_sticky", err_align, 1);
        align_on = 1'b1;

        // Shift and swap execute in the same cycle
        w_shift = 1'b1; in_weight_above = {4{19'd3}};
        tick();
        w_shift = 1'b0; w_swap = 1'b1;
        tick();
        w_swap = 1'b0;
        chk("t6_swap_exec_now", swap_done, 1);
        w_shift = 1'b1; in_weight_above = {4{19'd9}};
        tick();
        w_shift = 1'b0;
        chk("t6_shadow_new", out_weight_below, {4{19'd9}});
        act_in = 19'd2; act_in_valid = 1'b1;
        tick();
        act_in_valid = 1'b0;
        chk("t6_active_old_shadow", osum(0), 6);
        drain();

        // Reset while PENDING
        act_in = 19'd1; act_in_valid = 1'b1; w_swap = 1'b1;
        tick();
        act_in_valid = 1'b0; w_swap = 1'b0;
        chk("t6_pending_ready", act_in_ready, 0);
        chk("t6_pending_busy", swap_done, 0);
        rst = 1'b1;
        chk("t6_rst_no_done", swap_done, 0);
        tick();
        chk("t6_rst_ready", act_in_ready, 1);
        chk("t6_rst_sumv", out_sum_valid, 0);
        chk("t6_rst_err", err_align, 0);
        chk("t6_rst_weights", out_weight_below, 0);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            seen = seen | swap_done;
        end
        chk("t6_no_late_done", seen, 0);
        act_in = 19'd4; act_in_valid = 1'b1;
        in_sum[AW-1:0] = 38'd11;
        tick();
        act_in_valid = 1'b0; in_sum = '0;
        chk("t6_active_zero", osum(0), 11);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
